// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver with a valid/ready byte interface.
// It flags framing errors and overruns, and rejects false start bits.
module uart_rx_monitor #(
    parameter int CYCLES_PER_BIT = 16,
    parameter int CW             = $clog2(CYCLES_PER_BIT)
) (
    input  logic       g_clk,
    input  logic       g_resetn,
    input  logic       uart_rxd,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CYCLES_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rxd_m, rxd_s;
    logic [1:0]    sync_fill;
    logic          armed;
    logic          byte_done;
    logic          frame_bad;
    logic          cnt_zero;

    // Two-flop synchroniser on the asynchronous serial line.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // The synchroniser's reset value of 1 is not a real observation of the
    // line. Start detection is armed only after the chain has refilled and
    // rxd_s shows a genuine high. This keeps a line that is low when reset
    // releases from being taken as a start bit.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rxd_s)
                armed <= 1'b1;
        end
    end

    // Frame state register, bit-period counter, bit index and shifter.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);

    // Next-state logic. Every sample is taken at the middle of a bit period.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed && !rxd_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (rxd_s) begin
                        state_d = IDLE;              // glitch, not a start bit
                    end else begin
                        cnt_d   = FULL_LOAD;
                        idx_d   = 3'd0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_d = {rxd_s, shift_q[7:1]}; // LSB arrives first
                    cnt_d   = FULL_LOAD;
                    if (idx_q == 3'd7)
                        state_d = STOP;
                    else
                        idx_d = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    if (rxd_s) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;            // a back-to-back start is still caught
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BREAK: begin
                if (rxd_s)
                    state_d = IDLE;                  // a held-low line must not retrigger
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register, handshake and one-cycle error pulses.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rx_valid     <= 1'b0;
            rx_data      <= 8'h00;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= frame_bad;
            rx_overrun   <= byte_done && rx_valid && !rx_ready;
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor. Stimulus pushes the expected bytes into a queue.
// A negedge monitor pops an entry on each handshake and counts error pulses.
module tb_uart_rx_monitor;

    logic       g_clk = 1'b0;
    logic       g_resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int         n_checks = 0;
    int         n_fails = 0;
    int         cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         last_rise_cyc = 0;
    int         fall_cyc = 0;
    bit         prev_valid = 1'b0;
    bit         saw_busy;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx_monitor #(.CYCLES_PER_BIT(16)) dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .uart_rxd    (uart_rxd),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_busy     (rx_busy),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun)
    );

    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int expv);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge g_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_cyc(16);
        end
        uart_rxd = stop_bit;
        wait_cyc(16);
    endtask

    // Monitor: pops the scoreboard on each handshake and counts error pulses.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (rx_frame_err) fe_cnt++;
            if (rx_overrun)   ov_cnt++;
            if (rx_valid && !prev_valid) last_rise_cyc = cyc;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_byte", int'(rx_data), 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    check(rx_data == exp_b, "rx_data", int'(rx_data), int'(exp_b));
                end
            end
        end
        prev_valid = rx_valid;
    end

    initial begin
        wait_cyc(3);
        g_resetn = 1'b1;
        wait_cyc(20);

        // A single 0x55 byte, with its latency measured from the line edge.
        exp_q.push_back(8'h55);
        fall_cyc = cyc;
        send_frame(8'h55, 1'b1);
        wait_cyc(4);
        check((last_rise_cyc - fall_cyc) >= 154 && (last_rise_cyc - fall_cyc) <= 156,
              "latency_55", last_rise_cyc - fall_cyc, 155);
        check(fe_cnt == 0, "frame_err_55", fe_cnt, 0);

        // Two frames back to back, with no idle gap between them.
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_cyc(20);
        check(fe_cnt == 0 && ov_cnt == 0, "b2b_errors", fe_cnt + ov_cnt, 0);

        // A short low glitch, which must not be taken as a start bit.
        uart_rxd = 1'b0;
        wait_cyc(5);
        uart_rxd = 1'b1;
        wait_cyc(20);
        check(rx_busy == 1'b0, "glitch_busy", int'(rx_busy), 0);
        check(fe_cnt == 0, "glitch_frame_err", fe_cnt, 0);

        // Stop bit low, then the line held low: one framing error and no byte.
        send_frame(8'hFF, 1'b0);
        saw_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rx_busy) saw_busy = 1'b1;
            wait_cyc(1);
        end
        check(saw_busy, "break_busy", int'(saw_busy), 1);
        uart_rxd = 1'b1;
        wait_cyc(16);
        check(fe_cnt == 1, "frame_err_count", fe_cnt, 1);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        wait_cyc(20);

        // Overrun: the consumer stalls while two bytes arrive.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cyc(10);
        check(ov_cnt == 1, "overrun_count", ov_cnt, 1);
        check(rx_valid == 1'b1, "overrun_valid", int'(rx_valid), 1);
        check(rx_data == 8'h11, "overrun_data", int'(rx_data), 8'h11);
        exp_q.push_back(8'h11);
        rx_ready = 1'b1;
        wait_cyc(3);
        check(rx_valid == 1'b0, "overrun_drain", int'(rx_valid), 0);

        // Reset in the middle of data bit 4 of 0xC6 (bits LSB first: 0,1,1,0,0,0,1,1).
        uart_rxd = 1'b0;
        wait_cyc(16);
        uart_rxd = 1'b0; wait_cyc(16);
        uart_rxd = 1'b1; wait_cyc(16);
        uart_rxd = 1'b1; wait_cyc(16);
        uart_rxd = 1'b0; wait_cyc(16);
        uart_rxd = 1'b0;
        wait_cyc(8);
        g_resetn = 1'b0;
        wait_cyc(2);
        check(rx_valid == 1'b0, "rst_valid", int'(rx_valid), 0);
        check(rx_busy == 1'b0, "rst_busy", int'(rx_busy), 0);
        check(rx_frame_err == 1'b0, "rst_frame_err", int'(rx_frame_err), 0);
        check(rx_overrun == 1'b0, "rst_overrun", int'(rx_overrun), 0);
        check(rx_data == 8'h00, "rst_data", int'(rx_data), 0);
        g_resetn = 1'b1;
        wait_cyc(6);
        uart_rxd = 1'b0; wait_cyc(16);
        uart_rxd = 1'b1; wait_cyc(32);
        uart_rxd = 1'b1; wait_cyc(32);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);

        // Drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cyc(1);
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        check(fe_cnt == 1 && ov_cnt == 1, "final_error_counts", fe_cnt * 16 + ov_cnt, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Synthesizable UART receiver (8N1) that sits on the far end of the system's uart_txd line.
- Deserialises bytes and presents them on a valid/ready byte interface.
- Usable as a bench-side decoder for system output and as the RX half of the SoC UART peripheral.
- Detects and flags framing errors, false start bits and receive overruns.

Parameters:
- CYCLES_PER_BIT, 16, g_clk cycles per UART bit period; minimum 4.
- CW, $clog2(CYCLES_PER_BIT), width of the bit-period counter (derived; not overridden).

Ports:
- g_clk  input  1  system clock.
- g_resetn  input  1  asynchronous active-low reset.
- uart_rxd  input  1  asynchronous serial line; idle high.
- rx_valid  output  1  a received byte is held in rx_data.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- rx_data  output  8  received byte; stable while rx_valid is high.
- rx_busy  output  1  high in any state other than IDLE.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  output  1  one-cycle pulse: a byte completed while the holding register was still full.

Behaviour:
- Reset: all state is asynchronously cleared when g_resetn is low.
  - State = IDLE; rx_valid, rx_busy, rx_frame_err and rx_overrun = 0; rx_data = 8'h00.
  - Synchroniser flops reset to 1.
- Synchroniser: two-flop chain on uart_rxd; only the second flop (rxd_s) is used, giving 2 cycles of input latency.
- Bit counter: CW-bit down-counter; data-bit index is 3 bits.
- State machine:
  - IDLE: when rxd_s == 0, load counter with CYCLES_PER_BIT/2 - 1 and go to START.
  - START: decrement counter. At 0, sample rxd_s.
    - If 1: false start, return to IDLE; no flag raised.
    - If 0: load CYCLES_PER_BIT - 1, set index = 0, go to DATA.
  - DATA: at counter 0, shift rxd_s into shift[7] (LSB first, right shift) and reload the counter.
    - After index 7, go to STOP; otherwise increment index.
  - STOP: at counter 0, sample rxd_s.
    - If 1: byte complete, go to IDLE.
    - If 0: pulse rx_frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rxd_s == 1, then go to IDLE. This prevents a held-low line re-triggering as a start bit.
- Sample points: mid-bit for start, data and stop. The stop sample falls CYCLES_PER_BIT/2 + 9*CYCLES_PER_BIT cycles after rxd_s first goes low.
- Holding register and handshake:
  - On byte completion with rx_valid == 0: rx_data <= shift and rx_valid <= 1 on the next edge.
  - rx_valid falls on the edge after a cycle with rx_valid && rx_ready.
  - Completion while rx_valid && !rx_ready: new byte dropped, rx_data keeps the old byte, rx_overrun pulses for 1 cycle.
  - Completion in the same cycle as rx_valid && rx_ready: handshake accepted and new byte loaded; rx_valid stays 1, no overrun.
- Back-to-back frames: IDLE is re-entered at the mid-stop-bit sample, so a start edge arriving half a bit later is caught. No idle gap is required.
- rx_ready is ignored while rx_valid == 0.
- Reset mid-frame: the partial byte is lost. After g_resetn rises, the line must be seen high then low before a new frame is detected.

Test Plan (CYCLES_PER_BIT = 16, rx_ready held 1 unless stated):
- Send 8'h55, 8N1 -> rx_valid pulses once with rx_data = 8'h55, asserted 2 + 8 + 144 + 1 cycles (±1) after the uart_rxd falling edge; rx_frame_err = 0.
- Send 8'hA3 then 8'h0F back-to-back with no idle gap -> two accepted bytes, 8'hA3 then 8'h0F; no error pulses.
- Pulse uart_rxd low for 5 cycles only -> state returns to IDLE, rx_busy deasserts, no rx_valid and no error.
- Send 8'hFF with stop bit driven low, then hold the line low for 40 cycles -> one rx_frame_err pulse, no rx_valid; no new frame until the line returns high; a following 8'h12 is received correctly.
- rx_ready = 0; send 8'h11 then 8'h22 -> rx_data = 8'h11 stays valid, one rx_overrun pulse at the second stop sample; raising rx_ready consumes 8'h11 and rx_valid drops.
- Assert g_resetn low during data bit 4 of 8'hC6, release, then send 8'h3C -> only 8'h3C is received; all outputs are 0 during reset.
